// File: rtl/dsp_equation_accum.sv
// dsp_equation_accum: streams an input file through the file port and
// reduces it by sum, saturating sum, min or max.
module dsp_equation_accum #(
  parameter int dw    = 32,
  parameter int ACC_W = 48,
  parameter int DEBUG = 0
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          equation_enable,
  input  logic [dw-1:0] dsp_input0_reg,
  input  logic [dw-1:0] dsp_input1_reg,
  input  logic [dw-1:0] dsp_input3_reg,
  input  logic [1:0]    mode,
  output logic [7:0]    file_num,
  output logic          file_read,
  output logic          file_write,
  output logic [31:0]   file_write_data,
  input  logic [31:0]   file_read_data,
  input  logic          file_active,
  input  logic [31:0]   rd_ptr,
  input  logic [31:0]   wr_ptr,
  output logic          equation_done,
  output logic          interrupt,
  output logic          error,
  output logic [31:0]   dsp_output0_reg,
  output logic [31:0]   dsp_output1_reg,
  output logic [31:0]   dsp_output2_reg
);

  localparam int F_START  = 0;
  localparam int F_SZ_LSB = 1;
  localparam int F_SIGNED = 3;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [1:0] M_SUM = 2'd0;
  localparam logic [1:0] M_SAT = 2'd1;
  localparam logic [1:0] M_MIN = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_READ_WAIT,
    S_OP,
    S_WR_LO,
    S_WR_LO_WAIT,
    S_WR_HI,
    S_WR_HI_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic [1:0]         size_q;
  logic               sgn_q;
  logic [7:0]         out_file_q;
  logic [ACC_W-1:0]   acc_q;
  logic [31:0]        cnt_q;
  logic               first_q;
  logic               err_q;
  logic [31:0]        data_q;

  logic               start;
  logic [3:0][ACC_W-1:0] lane;
  logic [3:0]         lane_ok;
  logic [2:0]         inc;
  logic               bad_size;

  logic [ACC_W-1:0]   lsum;
  logic [ACC_W:0]     sum_x;
  logic [ACC_W-1:0]   sum_r;
  logic               ovf;
  logic [ACC_W-1:0]   sat_v;
  logic [ACC_W-1:0]   red;
  logic [ACC_W-1:0]   mm;
  logic [32:0]        cnt_x;
  logic [ACC_W-1:0]   acc_nxt;
  logic [31:0]        cnt_nxt;
  logic               first_nxt;
  logic               err_op;
  logic [63:0]        acc64;
  logic [31:0]        hi_word;

  logic               unused_ok;

  assign start = dsp_input0_reg[F_START] & equation_enable;
  assign error = err_q;

  function automatic logic [ACC_W-1:0] ext8(
    input logic [7:0] v,
    input logic       s
  );
    if (s) ext8 = ACC_W'($signed(v));
    else   ext8 = ACC_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] ext16(
    input logic [15:0] v,
    input logic        s
  );
    if (s) ext16 = ACC_W'($signed(v));
    else   ext16 = ACC_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] ext32(
    input logic [31:0] v,
    input logic        s
  );
    if (s) ext32 = ACC_W'($signed(v));
    else   ext32 = ACC_W'(v);
  endfunction

  function automatic logic lt(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic             s
  );
    if (s) lt = $signed(a) < $signed(b);
    else   lt = a < b;
  endfunction

  // Split the captured word into extended lanes
  always_comb begin
    lane     = '0;
    lane_ok  = 4'b0000;
    inc      = 3'd0;
    bad_size = 1'b0;
    unique case (1'b1)
      (size_q == SZ_WORD): begin
        lane[0] = ext32(data_q, sgn_q);
        lane_ok = 4'b0001;
        inc     = 3'd1;
      end
      (size_q == SZ_HALF): begin
        lane[0] = ext16(data_q[15:0], sgn_q);
        lane[1] = ext16(data_q[31:16], sgn_q);
        lane_ok = 4'b0011;
        inc     = 3'd2;
      end
      (size_q == SZ_BYTE): begin
        lane[0] = ext8(data_q[7:0], sgn_q);
        lane[1] = ext8(data_q[15:8], sgn_q);
        lane[2] = ext8(data_q[23:16], sgn_q);
        lane[3] = ext8(data_q[31:24], sgn_q);
        lane_ok = 4'b1111;
        inc     = 3'd4;
      end
      default: bad_size = 1'b1;
    endcase
  end

  // Next accumulator, count and error for the OP cycle
  always_comb begin
    lsum  = lane[0] + lane[1] + lane[2] + lane[3];
    sum_x = {1'b0, acc_q} + {1'b0, lsum};
    sum_r = sum_x[ACC_W-1:0];
    if (sgn_q)
      ovf = (acc_q[ACC_W-1] == lsum[ACC_W-1]) &&
            (sum_r[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf = sum_x[ACC_W];
    if (!sgn_q)
      sat_v = '1;
    else if (acc_q[ACC_W-1])
      sat_v = {1'b1, {(ACC_W-1){1'b0}}};
    else
      sat_v = {1'b0, {(ACC_W-1){1'b1}}};

    red = lane[0];
    for (int i = 1; i < 4; i++) begin
      if (lane_ok[i]) begin
        if (mode_q == M_MIN) begin
          if (lt(lane[i], red, sgn_q)) red = lane[i];
        end else begin
          if (lt(red, lane[i], sgn_q)) red = lane[i];
        end
      end
    end
    mm = acc_q;
    if (first_q)
      mm = red;
    else if (mode_q == M_MIN && lt(red, acc_q, sgn_q))
      mm = red;
    else if (mode_q != M_MIN && lt(acc_q, red, sgn_q))
      mm = red;

    cnt_x     = {1'b0, cnt_q} + {30'd0, inc};
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    first_nxt = first_q;
    err_op    = 1'b0;
    if (bad_size) begin
      err_op = 1'b1;
    end else begin
      cnt_nxt = cnt_x[31:0];
      err_op  = cnt_x[32];
      unique case (1'b1)
        (mode_q == M_SUM): begin
          acc_nxt = sum_r;
          err_op  = err_op | ovf;
        end
        (mode_q == M_SAT): begin
          acc_nxt = ovf ? sat_v : sum_r;
          err_op  = err_op | ovf;
        end
        default: begin
          acc_nxt   = mm;
          first_nxt = 1'b0;
        end
      endcase
    end
  end

  // Upper result word, extended to 32 bits by the sample signedness
  always_comb begin
    if (sgn_q) acc64 = 64'($signed(acc_q));
    else       acc64 = 64'(acc_q);
    hi_word = acc64[63:32];
  end

  // Control FSM with registered file-port and status outputs
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state           <= S_IDLE;
      mode_q          <= 2'd0;
      size_q          <= 2'd0;
      sgn_q           <= 1'b0;
      out_file_q      <= 8'd0;
      acc_q           <= '0;
      cnt_q           <= 32'd0;
      first_q         <= 1'b0;
      err_q           <= 1'b0;
      data_q          <= 32'd0;
      file_num        <= 8'd0;
      file_read       <= 1'b0;
      file_write      <= 1'b0;
      file_write_data <= 32'd0;
      equation_done   <= 1'b0;
      interrupt       <= 1'b0;
      dsp_output0_reg <= 32'd0;
      dsp_output1_reg <= 32'd0;
      dsp_output2_reg <= 32'd0;
    end else begin
      equation_done <= 1'b0;
      interrupt     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          file_read  <= 1'b0;
          file_write <= 1'b0;
          file_num   <= dsp_input1_reg[7:0];
          if (start) begin
            mode_q          <= mode;
            size_q          <= dsp_input0_reg[F_SZ_LSB +: 2];
            sgn_q           <= dsp_input0_reg[F_SIGNED];
            out_file_q      <= dsp_input3_reg[7:0];
            acc_q           <= '0;
            cnt_q           <= 32'd0;
            err_q           <= 1'b0;
            first_q         <= 1'b1;
            dsp_output0_reg <= 32'd0;
            dsp_output1_reg <= 32'd0;
            dsp_output2_reg <= 32'd0;
            if (rd_ptr == wr_ptr) begin
              file_num        <= dsp_input3_reg[7:0];
              file_write      <= 1'b1;
              file_write_data <= 32'd0;
              state           <= S_WR_LO;
            end else begin
              file_read <= 1'b1;
              state     <= S_READ;
            end
          end
        end
        S_READ: begin
          if (file_active) begin
            file_read <= 1'b0;
            state     <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (file_active) data_q <= file_read_data;
          else             state  <= S_OP;
        end
        S_OP: begin
          acc_q   <= acc_nxt;
          cnt_q   <= cnt_nxt;
          first_q <= first_nxt;
          if (err_op) err_q <= 1'b1;
          if (rd_ptr != wr_ptr) begin
            file_read <= 1'b1;
            state     <= S_READ;
          end else begin
            file_num        <= out_file_q;
            file_write      <= 1'b1;
            file_write_data <= acc_nxt[31:0];
            state           <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (file_active) begin
            file_write <= 1'b0;
            state      <= S_WR_LO_WAIT;
          end
        end
        S_WR_LO_WAIT: begin
          if (!file_active) begin
            file_write      <= 1'b1;
            file_write_data <= hi_word;
            state           <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          if (file_active) begin
            file_write <= 1'b0;
            state      <= S_WR_HI_WAIT;
          end
        end
        S_WR_HI_WAIT: begin
          if (!file_active) begin
            equation_done   <= 1'b1;
            interrupt       <= 1'b1;
            dsp_output0_reg <= acc_q[31:0];
            dsp_output1_reg <= hi_word;
            dsp_output2_reg <= cnt_q;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          file_read  <= 1'b0;
          file_write <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign unused_ok = ^{dsp_input0_reg[dw-1:4],
                       dsp_input1_reg[dw-1:8],
                       dsp_input3_reg[dw-1:8],
                       acc64[31:0]} ^ (DEBUG != 0);

endmodule
